// File: rtl/alp_seq_alu.sv
// Multi-cycle ALU: processes SLICE nibbles per clock, LSB chunk first, with the
// inter-chunk carry held in a register. Binary and packed-BCD add/sub, logic, pass.
module alp_seq_alu #(
  parameter int NIBBLES = 8,
  parameter int SLICE   = 1
) (
  input  logic                   clk_h,
  input  logic                   reset_h,
  input  logic                   start_h,
  input  logic [3:0]             alu_h,
  input  logic                   bcd_op_l,
  input  logic                   carry_in_h,
  input  logic [4*NIBBLES-1:0]   amux_h,
  input  logic [4*NIBBLES-1:0]   bmux_h,
  output logic                   busy_h,
  output logic                   done_h,
  output logic [4*NIBBLES-1:0]   aluq_h,
  output logic                   c_out_h,
  output logic                   v_out_h,
  output logic                   n_out_h,
  output logic                   z_out_h
);

  localparam int W     = 4 * NIBBLES;
  localparam int STEPS = NIBBLES / SLICE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int CHUNK = 4 * SLICE;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic [3:0]      op_q;
  logic            bcd_l_q;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;

  logic            arith, dec;
  logic            last;
  logic            carry_nx;
  logic            c3_nx;
  logic [CHUNK-1:0] chunk_res;
  logic [W-1:0]    aluq_nx;
  logic [3:0]      a_n, b_n, x_n, y_n, d_n;
  logic [4:0]      t;
  int              base;

  assign arith  = (op_q <= 4'd2);
  assign dec    = arith & ~bcd_l_q;
  assign last   = (cnt_q == CW'(STEPS - 1));
  assign busy_h = (state_q == RUN);

  // One chunk per clock; carry ripples through the SLICE nibbles of the chunk.
  // c3_nx is the carry into bit 3 of the chunk's top nibble (the word MSB on the last step).
  always_comb begin
    carry_nx  = carry_q;
    c3_nx     = 1'b0;
    chunk_res = '0;
    a_n = '0; b_n = '0; x_n = '0; y_n = '0; d_n = '0;
    t    = '0;
    base = 0;
    for (int j = 0; j < SLICE; j++) begin
      base = (int'(cnt_q) * SLICE + j) * 4;
      a_n  = a_q[base +: 4];
      b_n  = b_q[base +: 4];
      x_n  = a_n;
      y_n  = b_n;
      if (op_q == 4'd1) begin
        y_n = dec ? (4'd9 - b_n) : ~b_n;
      end else if (op_q == 4'd2) begin
        x_n = b_n;
        y_n = dec ? (4'd9 - a_n) : ~a_n;
      end
      t     = {1'b0, x_n} + {1'b0, y_n} + {4'b0, carry_nx};
      c3_nx = x_n[3] ^ y_n[3] ^ t[3];
      case (op_q)
        4'd0, 4'd1, 4'd2: begin
          if (dec) begin
            if (t > 5'd9) begin
              d_n      = t[3:0] + 4'd6;
              carry_nx = 1'b1;
            end else begin
              d_n      = t[3:0];
              carry_nx = 1'b0;
            end
          end else begin
            d_n      = t[3:0];
            carry_nx = t[4];
          end
        end
        4'd3:    d_n = a_n & b_n;
        4'd4:    d_n = a_n | b_n;
        4'd5:    d_n = a_n ^ b_n;
        4'd7:    d_n = b_n;
        default: d_n = a_n;
      endcase
      chunk_res[j*4 +: 4] = d_n;
    end
  end

  always_comb begin
    aluq_nx = aluq_h;
    aluq_nx[int'(cnt_q) * CHUNK +: CHUNK] = chunk_res;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_h) state_d = RUN;
      RUN:     if (last)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      bcd_l_q <= 1'b1;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done_h  <= 1'b0;
      aluq_h  <= '0;
      c_out_h <= 1'b0;
      v_out_h <= 1'b0;
      n_out_h <= 1'b0;
      z_out_h <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          done_h <= 1'b0;
          if (start_h) begin
            a_q     <= amux_h;
            b_q     <= bmux_h;
            op_q    <= alu_h;
            bcd_l_q <= bcd_op_l;
            carry_q <= carry_in_h;
            cnt_q   <= '0;
            aluq_h  <= '0;
            c_out_h <= 1'b0;
            v_out_h <= 1'b0;
            n_out_h <= 1'b0;
            z_out_h <= 1'b0;
          end
        end
        RUN: begin
          aluq_h  <= aluq_nx;
          carry_q <= carry_nx;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            done_h  <= 1'b1;
            c_out_h <= arith & carry_nx;
            v_out_h <= arith & bcd_l_q & (c3_nx ^ carry_nx);
            n_out_h <= ~dec & aluq_nx[W-1];
            z_out_h <= (aluq_nx == '0);
          end
        end
        default: done_h <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alp_seq_alu.sv
// Bench for alp_seq_alu: driver pushes expected results, a negedge monitor pops
// and compares on every done_h pulse; random ops checked against a word-level model.
module tb_alp_seq_alu;
  localparam int NIBBLES = 8;
  parameter  int SLICE   = 1;
  localparam int W       = 4 * NIBBLES;
  localparam int STEPS   = NIBBLES / SLICE;

  // valid/ready view: done_h is the only valid; the bench is always ready, so
  // each done_h pulse is one result transfer, matched in order against exp_q.
  typedef struct packed {
    logic [W-1:0] q;
    logic         c, v, n, z;
    logic [31:0]  start;
  } exp_t;

  logic          clk_h = 1'b0;
  logic          reset_h, start_h, bcd_op_l, carry_in_h;
  logic [3:0]    alu_h;
  logic [W-1:0]  amux_h, bmux_h;
  logic          busy_h, done_h, c_out_h, v_out_h, n_out_h, z_out_h;
  logic [W-1:0]  aluq_h;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            run_len  = 0;
  logic [31:0]   cyc      = 0;

  alp_seq_alu #(.NIBBLES(NIBBLES), .SLICE(SLICE)) dut (
    .clk_h(clk_h), .reset_h(reset_h), .start_h(start_h), .alu_h(alu_h),
    .bcd_op_l(bcd_op_l), .carry_in_h(carry_in_h), .amux_h(amux_h), .bmux_h(bmux_h),
    .busy_h(busy_h), .done_h(done_h), .aluq_h(aluq_h), .c_out_h(c_out_h),
    .v_out_h(v_out_h), .n_out_h(n_out_h), .z_out_h(z_out_h)
  );

  // clock / reset block
  initial forever #5 clk_h = ~clk_h;
  always @(posedge clk_h) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] q, input logic c, v, n, z);
    exp_t e;
    e = '0;
    e.q = q; e.c = c; e.v = v; e.n = n; e.z = z;
    return e;
  endfunction

  // Reference: whole-word arithmetic for binary, digit-by-digit decimal arithmetic for BCD.
  function automatic exp_t model(input logic [3:0] op, input logic bcd_l, input logic cin,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W:0]   s;
    logic [W-1:0] x, y, yb;
    logic         arith, dec;
    int           c, t, xd, yd;
    e     = '0;
    arith = (op <= 4'd2);
    dec   = arith && !bcd_l;
    if (!arith) begin
      case (op)
        4'd3:    e.q = a & b;
        4'd4:    e.q = a | b;
        4'd5:    e.q = a ^ b;
        4'd7:    e.q = b;
        default: e.q = a;
      endcase
    end else begin
      x  = (op == 4'd2) ? b : a;
      yb = (op == 4'd2) ? a : b;
      if (!dec) begin
        y   = (op == 4'd0) ? yb : ~yb;
        s   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
        e.q = s[W-1:0];
        e.c = s[W];
        e.v = (x[W-1] == y[W-1]) && (e.q[W-1] != x[W-1]);
      end else begin
        c = int'(cin);
        for (int i = 0; i < NIBBLES; i++) begin
          xd = int'(x[4*i +: 4]);
          yd = int'(yb[4*i +: 4]);
          if (op != 4'd0) yd = (9 - yd + 16) % 16;
          t = xd + yd + c;
          if (t > 9) begin
            e.q[4*i +: 4] = 4'((t + 6) % 16);
            c = 1;
          end else begin
            e.q[4*i +: 4] = 4'(t);
            c = 0;
          end
        end
        e.c = (c != 0);
      end
    end
    e.n = dec ? 1'b0 : e.q[W-1];
    e.z = (e.q == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_word(input bit digits);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < NIBBLES; i++)
      w[4*i +: 4] = digits ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
    return w;
  endfunction

  // driver tasks: called at a negedge; start_h is sampled at the following posedge
  task automatic issue(input logic [3:0] op, input logic bcd_l, input logic cin,
                       input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    alu_h = op; bcd_op_l = bcd_l; carry_in_h = cin; amux_h = a; bmux_h = b;
    start_h = 1'b1;
    e.start = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk_h);
    start_h = 1'b0;
    amux_h = rand_word(0); bmux_h = rand_word(0);
    alu_h = 4'($urandom_range(0, 15)); carry_in_h = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < STEPS + 20; i++) begin
      if (done_h === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk_h);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: done_h never seen, expected within %0d cycles", name, STEPS + 20);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk_h) begin
    exp_t e;
    if (reset_h !== 1'b1) begin
      if (done_h === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done_h=1 with no result expected at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          check("aluq", aluq_h, e.q);
          check("c_out", W'(c_out_h), W'(e.c));
          check("v_out", W'(v_out_h), W'(e.v));
          check("n_out", W'(n_out_h), W'(e.n));
          check("z_out", W'(z_out_h), W'(e.z));
          check("latency", W'(cyc - e.start), W'(STEPS));
          check("busy_cycles", W'(run_len), W'(STEPS));
        end
      end
      if (busy_h === 1'b1) begin
        run_len++;
        check("flags_in_run", W'({c_out_h, v_out_h, n_out_h, z_out_h, done_h}), W'(0));
      end else begin
        run_len = 0;
      end
    end
  end

  initial begin
    int          ign_step, rst_step, dones, idle;
    logic [3:0]  op;
    logic        bl, ci;
    logic [W-1:0] a, b;
    ign_step = (STEPS > 3) ? 3 : STEPS - 1;
    rst_step = (STEPS > 4) ? 4 : STEPS - 1;

    reset_h = 1'b1; start_h = 1'b0; alu_h = '0; bcd_op_l = 1'b1; carry_in_h = 1'b0;
    amux_h = '0; bmux_h = '0;
    repeat (3) @(negedge clk_h);
    check("reset_outputs", W'({busy_h, done_h, c_out_h, v_out_h, n_out_h, z_out_h}), W'(0));
    check("reset_aluq", aluq_h, '0);
    reset_h = 1'b0;
    @(negedge clk_h);

    // directed vectors
    issue(4'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1, 0, 0, 1));
    wait_done("bin_add_wrap"); @(negedge clk_h);
    issue(4'd0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 0, 1, 1, 0));
    wait_done("bin_add_ovf"); @(negedge clk_h);
    issue(4'd1, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0007, mk(32'hFFFF_FFFE, 0, 0, 1, 0));
    wait_done("bin_sub"); @(negedge clk_h);
    issue(4'd2, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0007, mk(32'h0000_0002, 1, 0, 0, 0));
    wait_done("bin_rsub"); @(negedge clk_h);
    issue(4'd0, 1'b0, 1'b0, 32'h0000_0999, 32'h0000_0001, mk(32'h0000_1000, 0, 0, 0, 0));
    wait_done("bcd_add"); @(negedge clk_h);
    issue(4'd1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0001, mk(32'h0000_0099, 1, 0, 0, 0));
    wait_done("bcd_sub"); @(negedge clk_h);
    issue(4'd5, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, mk(32'h0000_0000, 0, 0, 0, 1));
    wait_done("xor_zero"); @(negedge clk_h);
    issue(4'd12, 1'b0, 1'b1, 32'h9ABC_DEF0, 32'h1111_1111, mk(32'h9ABC_DEF0, 0, 0, 1, 0));
    wait_done("reserved_pass_a"); @(negedge clk_h);

    // start during RUN is ignored
    issue(4'd0, 1'b1, 1'b0, 32'h0000_0123, 32'h0000_0456, mk(32'h0000_0579, 0, 0, 0, 0));
    repeat (ign_step) @(negedge clk_h);
    alu_h = 4'd7; amux_h = 32'hDEAD_BEEF; bmux_h = 32'hCAFE_F00D; start_h = 1'b1;
    @(negedge clk_h);
    start_h = 1'b0;
    wait_done("ignored_start");
    repeat (STEPS + 3) @(negedge clk_h);

    // start in the done cycle is accepted
    issue(4'd4, 1'b1, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, mk(32'hF0F0_0F0F, 0, 0, 1, 0));
    wait_done("b2b_first");
    issue(4'd3, 1'b1, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, mk(32'h0F00_0F00, 0, 0, 0, 0));
    @(negedge clk_h);
    wait_done("b2b_second"); @(negedge clk_h);

    // reset mid-operation abandons it
    issue(4'd0, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, mk(32'h3333_3334, 0, 0, 0, 0));
    repeat (rst_step) @(negedge clk_h);
    reset_h = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk_h);
    reset_h = 1'b0;
    check("midrun_reset_ctrl", W'({busy_h, done_h, c_out_h, v_out_h, n_out_h, z_out_h}), W'(0));
    check("midrun_reset_aluq", aluq_h, '0);
    dones = 0;
    for (int i = 0; i < STEPS + 4; i++) begin
      @(negedge clk_h);
      if (done_h === 1'b1) dones++;
    end
    check("no_done_after_reset", W'(dones), W'(0));
    issue(4'd1, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_0001, mk(32'h0000_0999, 1, 0, 0, 0));
    wait_done("after_reset"); @(negedge clk_h);

    // random operations, sometimes back-to-back from the done cycle
    repeat (80) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 2));
      bl = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      a  = rand_word(!bl && ($urandom_range(0, 1) == 1));
      b  = rand_word(!bl && ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 7) == 0) b = a;
      idle = $urandom_range(0, 2);
      repeat (idle) @(negedge clk_h);
      issue(op, bl, ci, a, b, model(op, bl, ci, a, b));
      wait_done("random");
    end

    repeat (STEPS + 5) @(negedge clk_h);
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
